as_alurv_mc: RTL and testbench
==============================

// Module: as_alurv_mc
// PURPOSE
//  Parametrised multi-cycle integer ALU for RV32I/RV64I datapaths; successor of the combinational ALU.
//  Adds valid/ready handshake, an iterative shifter (optional), an iterative shift-add multiplier (MUL, low half),
//  and registered Z/N/C/V flags. Sits in EX stage; the stage stalls while in_ready_o/out_valid_o are low.
// PARAMETERS
//  XLEN        64  operand/result width (32 or 64)
//  SHIFT_ITER  0   0: barrel shift in one cycle; 1: shift one bit per cycle
//  SHAMT_W     $clog2(XLEN)  shift-amount width (derived, localparam)
// PORTS
//  clk_i       in   1         clock, rising edge
//  rst_i       in   1         synchronous reset, active high
//  in_valid_i  in   1         operation request valid
//  in_ready_o  out  1         block idle, can accept a request
//  data01_i    in   XLEN      operand A
//  data02_i    in   XLEN      operand B (shift amount in [SHAMT_W-1:0])
//  aluSel_i    in   4         operation, alu_op_e
//  out_valid_o out  1         result/flags valid
//  out_ready_i in   1         consumer accepts result
//  aluResult_o out  XLEN      result
//  aluZero_o / aluNega_o / aluCarr_o / aluOver_o  out 1 each  flags
//  aluIll_o    out  1         unsupported aluSel code was issued
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready_o=1, out_valid_o=0, aluResult_o=0, all flags 0, aluIll_o=0, counters 0.
//  - FSM IDLE -> EXEC -> DONE -> IDLE. One operation in flight; in_ready_o=1 only in IDLE.
//  - IDLE: in_valid_i&&in_ready_o latches operands and op. ADD/SUB/AND/OR/XOR/SLT/SLTU/illegal, and shifts when
//    SHIFT_ITER=0: go directly to DONE (result visible 1 cycle after accept). Iterative ops go to EXEC.
//  - EXEC shift (SHIFT_ITER=1): count=shamt; one bit per cycle; shamt=0 -> DONE next cycle (latency 1);
//    latency = shamt+1. SRA replicates the sign bit.
//  - EXEC MUL: shift-add, one multiplier bit per cycle, fixed XLEN cycles; latency XLEN+1; result=low XLEN bits.
//  - DONE: out_valid_o=1; result and flags held stable until out_ready_i=1, then IDLE next cycle.
//    out_ready_i while out_valid_o=0 ignored; in_valid_i outside IDLE ignored (not accepted, not queued).
//  - Flags (registered with result): Z=(result==0), N=result[XLEN-1] for every op.
//    ADD: C=carry-out of bit XLEN-1; V=signed overflow. SUB: A+~B+1, C=carry-out (1 = no borrow, 0-0 -> C=1),
//    V=signed overflow. All other ops: C=V=0.
//  - SLT/SLTU: result 1/0 zero-extended to XLEN. Adder is XLEN+1 bits wide; no truncation before flag extraction.
//  - Illegal aluSel: result=0, Z=1, N=C=V=0, aluIll_o=1 with out_valid_o; aluIll_o=0 for legal ops.
//  - rst_i mid-EXEC/DONE aborts: outputs return to reset values next edge, pending result lost.
// STRUCTURE
//  - as_pack: typedef enum logic [3:0] alu_op_e {ADD=0,SUB=1,AND=2,OR=3,XOR=4,SLT=5,SLTU=6,SLL=7,SRL=8,SRA=9,MUL=10};
//    typedef enum logic [1:0] alu_st_e {IDLE,EXEC,DONE}; localparam ALUSEL_W=4.
//  - One sub-module: as_alurv_mul (iterative shift-add multiplier, start/done, XLEN param); rest inline.
// TESTING
//  - XLEN=64 ADD 7fff..ff + 1: accept, out_valid 1 cycle later -> result 8000..00, N=1 V=1 C=0 Z=0.
//  - SUB 0-0 then 2-4 -> result 0 Z=1 C=1; then ffff..fe N=1 C=0 V=0; SUB 8000..00-2 -> 7fff..fe C=1 V=1.
//  - MUL ffff..ff * 3 -> ffff..fd, out_valid exactly XLEN+1=65 cycles after accept, C=V=0, in_ready_o=0 throughout.
//  - SHIFT_ITER=1: SRA 8000..00 by 4 -> f800..00 after 5 cycles; SLL by 0 -> data01 after 1 cycle.
//  - Backpressure: hold out_ready_i=0 for 10 cycles -> result/flags stable; in_valid_i pulses ignored; then 1 -> IDLE.
//  - rst_i asserted during MUL cycle 20 -> out_valid_o=0, in_ready_o=1 next cycle; aluSel=4'hF -> aluIll_o=1, Z=1.

Source files
------------

// File: rtl/as_alurv_mc_pkg.sv
//------------------------------------------------------------------------------
// Module      : as_pack
// Description : Shared opcode/state types for the multi-cycle RV integer ALU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package as_pack;

  localparam int ALUSEL_W = 4;

  typedef enum logic [ALUSEL_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9,
    MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_st_e;

  function automatic logic isShift(input logic [ALUSEL_W-1:0] sel);
    return (sel == SLL) || (sel == SRL) || (sel == SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/as_alurv_mc_mul.sv
//------------------------------------------------------------------------------
// Module      : as_alurv_mul
// Description : Iterative shift-add multiplier, low XLEN bits, one bit/cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module as_alurv_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // Bit 0 is consumed on the start edge, so done rises after XLEN steps total.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i) begin
        r_mcand  <= a_i << 1;
        r_mplier <= b_i >> 1;
        r_acc    <= b_i[0] ? a_i : '0;
        r_cnt    <= CNT_W'(1);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(XLEN-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done_o    = r_done;
  assign product_o = r_acc;

endmodule

`default_nettype wire

// File: rtl/as_alurv_mc.sv
//------------------------------------------------------------------------------
// Module      : as_alurv_mc
// Description : Multi-cycle RV32I/RV64I integer ALU with valid/ready handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module as_alurv_mc
  import as_pack::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_ITER = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     data01_i,
  input  logic [XLEN-1:0]     data02_i,
  input  logic [ALUSEL_W-1:0] aluSel_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     aluResult_o,
  output logic                aluZero_o,
  output logic                aluNega_o,
  output logic                aluCarr_o,
  output logic                aluOver_o,
  output logic                aluIll_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_st_e            r_state;
  alu_st_e            w_stateNext;
  alu_op_e            r_op;
  logic [XLEN-1:0]    r_shVal;
  logic [SHAMT_W-1:0] r_shCnt;
  logic [XLEN-1:0]    r_result;
  logic               r_zero;
  logic               r_nega;
  logic               r_carr;
  logic               r_over;
  logic               r_ill;

  logic [SHAMT_W-1:0] w_shamtIn;
  logic               w_accept;
  logic               w_iter;
  logic               w_isSub;
  logic [XLEN-1:0]    w_bOp;
  logic [XLEN:0]      w_sum;
  logic               w_ovf;
  logic [XLEN-1:0]    w_res;
  logic               w_carr;
  logic               w_over;
  logic               w_ill;
  logic [XLEN-1:0]    w_shStep;
  logic [XLEN-1:0]    w_execRes;
  logic               w_execDone;
  logic               w_mulStart;
  logic               w_mulDone;
  logic [XLEN-1:0]    w_mulProd;

  assign w_shamtIn  = data02_i[SHAMT_W-1:0];
  assign w_accept   = in_valid_i && (r_state == IDLE);
  // A zero-distance shift has nothing to iterate, so it completes like a one-cycle op.
  assign w_iter     = (aluSel_i == MUL) ||
                      ((SHIFT_ITER != 0) && isShift(aluSel_i) && (w_shamtIn != '0));
  assign w_mulStart = w_accept && (aluSel_i == MUL);

  as_alurv_mul #(
    .XLEN (XLEN)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_mulStart),
    .a_i       (data01_i),
    .b_i       (data02_i),
    .done_o    (w_mulDone),
    .product_o (w_mulProd)
  );

  // Single-cycle datapath; the XLEN+1 bit sum keeps the carry for flag extraction.
  always_comb begin
    w_isSub = (aluSel_i == SUB) || (aluSel_i == SLT) || (aluSel_i == SLTU);
    w_bOp   = w_isSub ? ~data02_i : data02_i;
    w_sum   = {1'b0, data01_i} + {1'b0, w_bOp} + {{XLEN{1'b0}}, w_isSub};
    w_ovf   = (data01_i[XLEN-1] == w_bOp[XLEN-1]) && (w_sum[XLEN-1] != data01_i[XLEN-1]);
    w_res   = '0;
    w_carr  = 1'b0;
    w_over  = 1'b0;
    w_ill   = 1'b0;
    case (aluSel_i)
      ADD, SUB: begin
        w_res  = w_sum[XLEN-1:0];
        w_carr = w_sum[XLEN];
        w_over = w_ovf;
      end
      AND:  w_res = data01_i & data02_i;
      OR:   w_res = data01_i | data02_i;
      XOR:  w_res = data01_i ^ data02_i;
      SLT:  w_res = {{(XLEN-1){1'b0}}, w_sum[XLEN-1] ^ w_ovf};
      SLTU: w_res = {{(XLEN-1){1'b0}}, ~w_sum[XLEN]};
      SLL:  w_res = data01_i << w_shamtIn;
      SRL:  w_res = data01_i >> w_shamtIn;
      SRA:  w_res = $unsigned($signed(data01_i) >>> w_shamtIn);
      MUL:  w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_shStep = r_shVal;
    case (r_op)
      SLL:     w_shStep = {r_shVal[XLEN-2:0], 1'b0};
      SRL:     w_shStep = {1'b0, r_shVal[XLEN-1:1]};
      SRA:     w_shStep = {r_shVal[XLEN-1], r_shVal[XLEN-1:1]};
      default: w_shStep = r_shVal;
    endcase
  end

  assign w_execDone = (r_op == MUL) ? w_mulDone : (r_shCnt == SHAMT_W'(1));
  assign w_execRes  = (r_op == MUL) ? w_mulProd : w_shStep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid_i)  w_stateNext = w_iter ? EXEC : DONE;
      EXEC:    if (w_execDone)  w_stateNext = DONE;
      DONE:    if (out_ready_i) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op     <= ADD;
      r_shVal  <= '0;
      r_shCnt  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_nega   <= 1'b0;
      r_carr   <= 1'b0;
      r_over   <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= alu_op_e'(aluSel_i);
      r_shVal <= data01_i;
      r_shCnt <= w_shamtIn;
      if (!w_iter) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_nega   <= w_res[XLEN-1];
        r_carr   <= w_carr;
        r_over   <= w_over;
        r_ill    <= w_ill;
      end
    end else if (r_state == EXEC) begin
      r_shVal <= w_shStep;
      r_shCnt <= r_shCnt - SHAMT_W'(1);
      if (w_execDone) begin
        r_result <= w_execRes;
        r_zero   <= (w_execRes == '0);
        r_nega   <= w_execRes[XLEN-1];
        r_carr   <= 1'b0;
        r_over   <= 1'b0;
        r_ill    <= 1'b0;
      end
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign aluResult_o = r_result;
  assign aluZero_o   = r_zero;
  assign aluNega_o   = r_nega;
  assign aluCarr_o   = r_carr;
  assign aluOver_o   = r_over;
  assign aluIll_o    = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_as_alurv_mc.sv
//------------------------------------------------------------------------------
// Module      : tb_as_alurv_mc
// Description : Self-checking bench for as_alurv_mc, barrel and iterative shift.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_as_alurv_mc;
  import as_pack::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inValid  [2];
  logic            inReady  [2];
  logic            outValid [2];
  logic            outReady [2];
  logic [XLEN-1:0] dA;
  logic [XLEN-1:0] dB;
  logic [3:0]      sel;
  logic [XLEN-1:0] res [2];
  logic            zf  [2];
  logic            nf  [2];
  logic            cf  [2];
  logic            vf  [2];
  logic            il  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  as_alurv_mc #(.XLEN(XLEN), .SHIFT_ITER(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[0]), .in_ready_o(inReady[0]),
    .data01_i(dA), .data02_i(dB), .aluSel_i(sel), .out_valid_o(outValid[0]),
    .out_ready_i(outReady[0]), .aluResult_o(res[0]), .aluZero_o(zf[0]),
    .aluNega_o(nf[0]), .aluCarr_o(cf[0]), .aluOver_o(vf[0]), .aluIll_o(il[0])
  );

  as_alurv_mc #(.XLEN(XLEN), .SHIFT_ITER(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid[1]), .in_ready_o(inReady[1]),
    .data01_i(dA), .data02_i(dB), .aluSel_i(sel), .out_valid_o(outValid[1]),
    .out_ready_i(outReady[1]), .aluResult_o(res[1]), .aluZero_o(zf[1]),
    .aluNega_o(nf[1]), .aluCarr_o(cf[1]), .aluOver_o(vf[1]), .aluIll_o(il[1])
  );

  typedef struct {
    int              inst;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    logic            z, n, c, v, ill;
    int              lat;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: exact arithmetic, then wrap; latency counts the accept edge as 1.
  function automatic void refModel(input int inst, input logic [3:0] op,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   output logic [XLEN-1:0] r, output logic z, output logic n,
                                   output logic c, output logic v, output logic ill,
                                   output int lat);
    logic signed [XLEN:0] exact;
    int sh;
    sh = int'(b[5:0]);
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'd0: begin
        r = a + b;
        c = ({1'b0, a} + {1'b0, b}) > {1'b0, {XLEN{1'b1}}};
        exact = $signed({a[XLEN-1], a}) + $signed({b[XLEN-1], b});
        v = (exact != $signed({r[XLEN-1], r}));
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        exact = $signed({a[XLEN-1], a}) - $signed({b[XLEN-1], b});
        v = (exact != $signed({r[XLEN-1], r}));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd6: r = (a < b) ? 64'd1 : 64'd0;
      4'd7: begin r = a << sh; if (inst == 1) lat = sh + 1; end
      4'd8: begin r = a >> sh; if (inst == 1) lat = sh + 1; end
      4'd9: begin r = $signed(a) >>> sh; if (inst == 1) lat = sh + 1; end
      4'd10: begin r = a * b; lat = XLEN + 1; end
      default: ill = 1'b1;
    endcase
    z = (r == '0);
    n = r[XLEN-1];
  endfunction

  task automatic runOp(input int k, input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] er,
                       input logic ez, input logic en, input logic ec, input logic ev,
                       input logic eil, input int elat, input string tag);
    int lat;
    logic busyOk;
    @(negedge clk);
    sel = op; dA = a; dB = b; inValid[k] = 1'b1;
    @(posedge clk); #1;
    inValid[k] = 1'b0;
    lat = 1;
    busyOk = 1'b1;
    while (!outValid[k] && lat < 300) begin
      if (inReady[k]) busyOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " result"}, res[k], er);
    chk({tag, " flags ZNCV"}, 64'({zf[k], nf[k], cf[k], vf[k]}), 64'({ez, en, ec, ev}));
    chk({tag, " ill"}, 64'(il[k]), 64'(eil));
    chk({tag, " ready low while busy"}, 64'(busyOk), 64'd1);
    @(negedge clk); outReady[k] = 1'b1;
    @(posedge clk); #1;
    outReady[k] = 1'b0;
    chk({tag, " back to idle"}, 64'({inReady[k], outValid[k]}), 64'b10);
  endtask

  initial begin
    logic [XLEN-1:0] a, b, r;
    logic z, n, c, v, ill;
    int lat, k;
    logic [3:0] op;

    inValid[0] = 1'b0; inValid[1] = 1'b0;
    outReady[0] = 1'b0; outReady[1] = 1'b0;
    dA = '0; dB = '0; sel = '0;

    tbl[0]  = '{0, ADD,   64'h7fffffffffffffff, 64'h1, 64'h8000000000000000, 1'b0,1'b1,1'b0,1'b1,1'b0, 1};
    tbl[1]  = '{0, SUB,   64'h0, 64'h0, 64'h0, 1'b1,1'b0,1'b1,1'b0,1'b0, 1};
    tbl[2]  = '{0, SUB,   64'h2, 64'h4, 64'hfffffffffffffffe, 1'b0,1'b1,1'b0,1'b0,1'b0, 1};
    tbl[3]  = '{0, SUB,   64'h8000000000000000, 64'h2, 64'h7ffffffffffffffe, 1'b0,1'b0,1'b1,1'b1,1'b0, 1};
    tbl[4]  = '{0, MUL,   64'hffffffffffffffff, 64'h3, 64'hfffffffffffffffd, 1'b0,1'b1,1'b0,1'b0,1'b0, 65};
    tbl[5]  = '{0, SLT,   64'hffffffffffffffff, 64'h1, 64'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    tbl[6]  = '{0, SLTU,  64'hffffffffffffffff, 64'h1, 64'h0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1};
    tbl[7]  = '{0, 4'hF,  64'h55, 64'h55, 64'h0, 1'b1,1'b0,1'b0,1'b0,1'b1, 1};
    tbl[8]  = '{1, SRA,   64'h8000000000000000, 64'h4, 64'hf800000000000000, 1'b0,1'b1,1'b0,1'b0,1'b0, 5};
    tbl[9]  = '{1, SLL,   64'h0123456789abcdef, 64'h0, 64'h0123456789abcdef, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    tbl[10] = '{0, SRA,   64'h8000000000000000, 64'h4, 64'hf800000000000000, 1'b0,1'b1,1'b0,1'b0,1'b0, 1};
    tbl[11] = '{1, SRL,   64'hffffffffffffffff, 64'd63, 64'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 64};
    tbl[12] = '{0, ADD,   64'hffffffffffffffff, 64'h1, 64'h0, 1'b1,1'b0,1'b1,1'b0,1'b0, 1};
    tbl[13] = '{0, XOR,   64'hf0f0f0f0f0f0f0f0, 64'hff00ff00ff00ff00, 64'h0ff00ff00ff00ff0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    tbl[14] = '{1, MUL,   64'h100000000, 64'h100000000, 64'h0, 1'b1,1'b0,1'b0,1'b0,1'b0, 65};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 64'(inReady[0]), 64'd1);
    chk("reset valid", 64'(outValid[0]), 64'd0);
    chk("reset result", res[0], 64'd0);
    chk("reset flags+ill", 64'({zf[0], nf[0], cf[0], vf[0], il[0]}), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      runOp(tbl[i].inst, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, tbl[i].n,
            tbl[i].c, tbl[i].v, tbl[i].ill, tbl[i].lat, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      k  = int'($urandom_range(0, 1));
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'h8000000000000000;
        1: b = a;
        2: a = 64'hffffffffffffffff;
        default: ;
      endcase
      refModel(k, op, a, b, r, z, n, c, v, ill, lat);
      runOp(k, op, a, b, r, z, n, c, v, ill, lat, $sformatf("rnd%0d op%0d inst%0d", i, op, k));
    end

    // Backpressure: result must hold and new requests must be dropped.
    @(negedge clk); sel = ADD; dA = 64'd5; dB = 64'd6; inValid[0] = 1'b1;
    @(posedge clk); #1; inValid[0] = 1'b0;
    chk("bp first valid", 64'(outValid[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); inValid[0] = i[0]; sel = SUB; dA = {$urandom, $urandom}; dB = 64'd1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d result", i), res[0], 64'd11);
      chk($sformatf("bp%0d valid/ready", i), 64'({outValid[0], inReady[0]}), 64'b10);
    end
    @(negedge clk); inValid[0] = 1'b0; outReady[0] = 1'b1;
    @(posedge clk); #1; outReady[0] = 1'b0;
    chk("bp release", 64'({inReady[0], outValid[0]}), 64'b10);
    @(posedge clk); #1;
    chk("bp nothing queued", 64'(outValid[0]), 64'd0);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk); sel = MUL; dA = 64'd7; dB = 64'd9; inValid[0] = 1'b1;
    @(posedge clk); #1; inValid[0] = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort valid/ready", 64'({outValid[0], inReady[0]}), 64'b01);
    chk("abort result", res[0], 64'd0);
    chk("abort flags", 64'({zf[0], nf[0], cf[0], vf[0], il[0]}), 64'd0);
    @(negedge clk); rst = 1'b0;
    begin
      logic stale;
      stale = 1'b0;
      repeat (80) begin
        @(posedge clk); #1;
        if (outValid[0] || !inReady[0]) stale = 1'b1;
      end
      chk("abort no stale result", 64'(stale), 64'd0);
    end
    runOp(0, 4'hF, 64'h1234, 64'h5678, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, "ill after reset");
    runOp(0, ADD, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "ill cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
